// File: rtl/dma_wr_seq_pkg.sv
// Shared types and constants for the DMA write sequencer.
package dma_wr_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int CL_BYTES = 64;

endpackage

// File: rtl/dma_wr_seq_line_counter.sv
// Line counter with clear, enable and a flag that fires on the step reaching
// the limit; the count saturates at the limit so surplus events are ignored.
module dma_line_counter #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         hit
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         step;

   assign step = en && (cnt_q != limit);
   assign hit  = step && ((cnt_q + W'(1)) == limit);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (step) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // NOTE: state updates use non-blocking assignments so all flops sample together.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dma_wr_seq.sv
// Write-side DMA sequencer: drains cache lines from a show-ahead FIFO into the
// DMA write channel at incrementing addresses and reports completion on acks.
module dma_wr_seq
   import dma_wr_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int SIZE_WIDTH = 17,
   parameter int DATA_WIDTH = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [SIZE_WIDTH-1:0] size,
   output logic                  done,
   output logic                  busy,
   input  logic                  src_empty,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_rd_en,
   output logic                  dma_wr_en,
   output logic [ADDR_WIDTH-1:0] dma_wr_addr,
   output logic [DATA_WIDTH-1:0] dma_wr_data,
   input  logic                  dma_wr_full,
   input  logic                  dma_wr_ack
);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  start, wr_fire, ack_en;
   logic                  issue_hit, ack_hit;

   assign start   = go && (state_q == IDLE || state_q == DONE);
   assign wr_fire = (state_q == WRITE) && !src_empty && !dma_wr_full;
   assign ack_en  = dma_wr_ack && (state_q == WRITE || state_q == DRAIN);

   dma_line_counter #(.W(SIZE_WIDTH)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (start),
      .en    (wr_fire),
      .limit (size_q),
      .hit   (issue_hit)
   );

   dma_line_counter #(.W(SIZE_WIDTH)) u_ack_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (start),
      .en    (ack_en),
      .limit (size_q),
      .hit   (ack_hit)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      case (state_q)
         IDLE, DONE: begin
            if (go) begin
               addr_d  = wr_addr;
               size_d  = size;
               state_d = (size != '0) ? WRITE : DONE;
            end
         end
         WRITE: begin
            if (wr_fire) begin
               addr_d = addr_q + ADDR_WIDTH'(CL_BYTES);
            end
            // The final ack can land while the last line is still being issued.
            if (ack_hit) begin
               state_d = DONE;
            end else if (issue_hit) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (ack_hit) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == WRITE) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign done        = done_q;
   assign busy        = busy_q;
   assign dma_wr_en   = wr_fire;
   assign src_rd_en   = wr_fire;
   assign dma_wr_addr = addr_q;
   assign dma_wr_data = src_data;

endmodule

// File: tb/tb_dma_wr_seq.sv
// Scoreboard bench for dma_wr_seq: a per-transfer reference model predicts the
// write stream and done/busy levels; a negedge monitor compares every cycle.
module tb_dma_wr_seq;

   localparam int AW = 64;
   localparam int SW = 17;
   localparam int DW = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic          go;
   logic [AW-1:0] wr_addr;
   logic [SW-1:0] size;
   logic          done, busy;
   logic          src_empty = 1'b1;
   logic [DW-1:0] src_data  = '0;
   logic          src_rd_en, dma_wr_en;
   logic [AW-1:0] dma_wr_addr;
   logic [DW-1:0] dma_wr_data;
   logic          dma_wr_full = 1'b0;
   logic          dma_wr_ack  = 1'b0;

   dma_wr_seq #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .go          (go),
      .wr_addr     (wr_addr),
      .size        (size),
      .done        (done),
      .busy        (busy),
      .src_empty   (src_empty),
      .src_data    (src_data),
      .src_rd_en   (src_rd_en),
      .dma_wr_en   (dma_wr_en),
      .dma_wr_addr (dma_wr_addr),
      .dma_wr_data (dma_wr_data),
      .dma_wr_full (dma_wr_full),
      .dma_wr_ack  (dma_wr_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           exp_q[$];
   logic [DW-1:0] fifo_q[$];
   int            ack_due_q[$];

   int n_vec = 0, n_err = 0, cyc = 0, writes_seen = 0;
   int empty_pct = 0, full_mode = 0, ack_lat = 3;
   bit stray_en = 1'b0;

   // Reference model of one transfer, expressed as line/ack counts.
   bit m_active = 1'b0, m_done = 1'b0;
   int m_size = 0, m_issued = 0, m_acked = 0;
   bit exp_en;
   wr_t w;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Drive FIFO/DMA-side inputs, then check outputs and advance the model.
   always begin
      @(negedge clk);
      cyc++;
      src_empty = (fifo_q.size() == 0) || ($urandom_range(99) < empty_pct);
      src_data  = (fifo_q.size() != 0) ? fifo_q[0] : rand_line();
      case (full_mode)
         1:       dma_wr_full = cyc[0];
         2:       dma_wr_full = 1'($urandom_range(1));
         default: dma_wr_full = 1'b0;
      endcase
      dma_wr_ack = 1'b0;
      if (ack_due_q.size() != 0 && ack_due_q[0] <= cyc) begin
         dma_wr_ack = 1'b1;
         ack_due_q.delete(0);
      end else if (stray_en) begin
         dma_wr_ack = 1'($urandom_range(1));
      end
      #1;
      check("busy", busy, m_active);
      check("done", done, m_done);
      exp_en = m_active && (m_issued < m_size) && !src_empty && !dma_wr_full;
      check("dma_wr_en", dma_wr_en, exp_en);
      check("src_rd_en", src_rd_en, exp_en);
      if (dma_wr_en) begin
         writes_seen++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_write: got write at %0h want no write", dma_wr_addr);
         end else begin
            w = exp_q.pop_front();
            check("wr_addr", dma_wr_addr, w.addr);
            check("wr_data", dma_wr_data, w.data);
         end
         if (fifo_q.size() != 0) fifo_q.delete(0);
         ack_due_q.push_back(cyc + ack_lat);
      end
      if (rst) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_size   = 0;
         m_issued = 0;
         m_acked  = 0;
         exp_q.delete();
         fifo_q.delete();
      end else if (!m_active && go) begin
         m_size   = int'(size);
         m_issued = 0;
         m_acked  = 0;
         m_done   = (size == '0);
         m_active = (size != '0);
         fifo_q.delete();
         for (int i = 0; i < m_size + 2; i++) begin
            logic [DW-1:0] line;
            line = rand_line();
            fifo_q.push_back(line);
            if (i < m_size) begin
               w.addr = wr_addr + AW'(64 * i);
               w.data = line;
               exp_q.push_back(w);
            end
         end
      end else if (m_active) begin
         if (dma_wr_en) m_issued++;
         if (dma_wr_ack && m_acked < m_size) begin
            m_acked++;
            if (m_acked == m_size) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end
      end
   end

   task automatic start(input logic [AW-1:0] a, input int n);
      @(posedge clk);
      #1;
      wr_addr = a;
      size    = SW'(n);
      go      = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_done"}, done, 1'b1);
      check({name, "_pending"}, exp_q.size(), 0);
   endtask

   initial begin
      int            w0, n;
      logic [AW-1:0] ra;
      rst     = 1'b1;
      go      = 1'b0;
      wr_addr = '0;
      size    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_en", dma_wr_en, 1'b0);
      check("rst_rd_en", src_rd_en, 1'b0);
      check("rst_addr", dma_wr_addr, '0);
      check("rst_data", dma_wr_data, src_data);
      rst = 1'b0;

      // Basic 4-line transfer, no stalls.
      w0 = writes_seen;
      start(64'h1000, 4);
      wait_done("t1");
      check("t1_writes", writes_seen - w0, 4);

      // Zero-length transfer completes the cycle after go.
      w0 = writes_seen;
      start(64'h2000, 0);
      check("t2_done", done, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("t2_writes", writes_seen - w0, 0);

      // Backpressure toggling and random FIFO underflow.
      full_mode = 1;
      empty_pct = 40;
      ra        = {$urandom, $urandom};
      ra[5:0]   = '0;
      w0        = writes_seen;
      start(ra, 8);
      wait_done("t3");
      check("t3_writes", writes_seen - w0, 8);

      // go during the transfer must be ignored.
      full_mode = 2;
      empty_pct = 20;
      w0        = writes_seen;
      start(64'h4_0000, 16);
      repeat (5) @(posedge clk);
      #1;
      wr_addr = 64'hDEAD_0000;
      size    = 3;
      go      = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      wait_done("t4");
      check("t4_writes", writes_seen - w0, 16);

      // Restart straight from DONE.
      full_mode = 0;
      empty_pct = 0;
      w0        = writes_seen;
      start(64'h8000, 2);
      check("t4b_done_clr", done, 1'b0);
      wait_done("t4b");
      check("t4b_writes", writes_seen - w0, 2);

      // Reset in the middle of a 10-line transfer.
      w0 = writes_seen;
      start(64'h5000, 10);
      n = 0;
      while (writes_seen - w0 < 3 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t5_three_writes", (writes_seen - w0 >= 3), 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5_busy", busy, 1'b0);
      check("t5_done", done, 1'b0);
      check("t5_wr_en", dma_wr_en, 1'b0);
      check("t5_rd_en", src_rd_en, 1'b0);
      check("t5_addr", dma_wr_addr, '0);
      rst      = 1'b0;
      stray_en = 1'b1;
      repeat (10) @(posedge clk);
      stray_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t5_idle_busy", busy, 1'b0);
      w0 = writes_seen;
      start(64'h0, 1);
      wait_done("t5b");
      check("t5b_writes", writes_seen - w0, 1);

      // Address wrap at the top of the address space; late acks ignored.
      w0 = writes_seen;
      start(64'hFFFF_FFFF_FFFF_FF80, 3);
      wait_done("t6");
      check("t6_writes", writes_seen - w0, 3);
      stray_en = 1'b1;
      repeat (10) @(posedge clk);
      stray_en = 1'b0;
      #1;
      check("t6_done_hold", done, 1'b1);
      check("t6_busy_hold", busy, 1'b0);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dma_wr_seq.md
# dma_wr_seq

Write-side DMA sequencer between the MMIO memory map and the platform DMA write channel. Started by the one-cycle `go` pulse and the `wr_addr`/`size` registers. Drains cache lines from an upstream show-ahead FIFO and issues one write per line at incrementing byte addresses. Counts write acknowledgements and raises `done` once every line is acknowledged.

## Interface
Parameters:
- ADDR_WIDTH, 64, width of the virtual byte address
- SIZE_WIDTH, 17, width of the line count; max transfer is 2**SIZE_WIDTH-1 lines
- DATA_WIDTH, 512, cache-line width in bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; the single clock is clk
- go  in  1  start pulse from the memory map
- wr_addr  in  ADDR_WIDTH  starting byte address, 64-byte aligned
- size  in  SIZE_WIDTH  number of cache lines
- done  out  1  transfer complete, level
- busy  out  1  high in WRITE or DRAIN
- src_empty  in  1  upstream FIFO empty
- src_data  in  DATA_WIDTH  upstream FIFO head (show-ahead)
- src_rd_en  out  1  pop upstream FIFO
- dma_wr_en  out  1  write request
- dma_wr_addr  out  ADDR_WIDTH  write byte address
- dma_wr_data  out  DATA_WIDTH  write data
- dma_wr_full  in  1  DMA channel backpressure
- dma_wr_ack  in  1  one pulse per completed write

## Operation
- States: IDLE, WRITE, DRAIN, DONE.
- IDLE or DONE, go=1:
  - Latch wr_addr into addr_r and size into size_r; clear issue_cnt and ack_cnt; clear done.
  - Next state is WRITE if size≠0, else DONE.
- WRITE:
  - dma_wr_en = !src_empty && !dma_wr_full. This is combinational from state and inputs.
  - src_rd_en = dma_wr_en. dma_wr_data = src_data. dma_wr_addr = addr_r.
  - On each write: addr_r += 64 and issue_cnt += 1.
  - When a write brings issue_cnt to size_r, go to DRAIN.
- WRITE/DRAIN: each dma_wr_ack increments ack_cnt. When ack_cnt reaches size_r, go to DONE. The check includes the ack arriving in the same cycle.
- DONE: done=1 until the next go. go in DONE restarts immediately.
- go in WRITE or DRAIN is ignored.
- dma_wr_ack while in IDLE or DONE, or beyond size_r, is ignored. ack_cnt saturates at size_r.
- Arithmetic:
  - addr_r wraps modulo 2**ADDR_WIDTH with no error.
  - Counters are SIZE_WIDTH bits; comparisons are equality.
- Reset values:
  - state IDLE; done 0, busy 0, dma_wr_en 0, src_rd_en 0.
  - addr_r, size_r, issue_cnt, ack_cnt all 0.
  - dma_wr_addr 0, dma_wr_data follows src_data.
- rst mid-transfer: returns to IDLE next edge. Outstanding acks are dropped, and acks arriving after reset are ignored.

## Timing
- go sampled at edge N → state WRITE after N. The first dma_wr_en can assert in cycle N+1.
- Throughput is one line per cycle while !src_empty && !dma_wr_full.
- Ack and issue in the same cycle are both counted.
- The last ack sampled at edge M → done=1 and busy=0 from cycle M+1.
- size=0: done=1 in the cycle after go; no write is issued.
- busy and done are registered from state and are never high together.

## Structure
- Package dma_wr_seq_pkg:
  - state_t enum {IDLE, WRITE, DRAIN, DONE}
  - CL_BYTES=64
- Sub-module dma_line_counter: a SIZE_WIDTH-bit counter with clear, enable and an equality-to-limit flag. It is instantiated twice, once for issue and once for ack.
- Top level holds the FSM, the address register and the output muxing, about 150–250 lines.

## Test plan
- go, wr_addr=0x1000, size=4; FIFO always non-empty; full=0; ack 3 cycles after each write → writes at 0x1000, 0x1040, 0x1080, 0x10C0 on consecutive cycles; done rises the cycle after the 4th ack.
- size=0 → done=1 the cycle after go; dma_wr_en never asserts.
- size=8 with dma_wr_full toggling every other cycle and src_empty random → exactly 8 writes, addresses contiguous, no write while full or empty, data order matches FIFO order.
- go pulsed again mid-transfer (size=16) → ignored: 16 writes total and the address is not reloaded. go in DONE with size=2 → done clears, 2 new writes.
- rst asserted after 3 of 10 writes → next cycle IDLE with all outputs at reset values. A later go, wr_addr=0x0, size=1 completes normally despite stray acks.
- wr_addr=2**64-128, size=3 → addresses 0xFFFF_FFFF_FFFF_FF80, 0xFFFF_FFFF_FFFF_FFC0, 0x0; extra acks after done are ignored.
